// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header size and parser states for the UART command processor.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'hA0;
  localparam logic [7:0] OP_MUL32 = 8'hB0;

  localparam int unsigned HDR_BYTES = 4;

  typedef enum logic [2:0] {
    P_IDLE,
    P_RSVD,
    P_LEN_LO,
    P_LEN_HI,
    P_PAYLOAD,
    P_DONE
  } parser_state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_ECHO) || (b == OP_ADD32) || (b == OP_MUL32);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, half-bit start qualification, mid-bit sampling.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Synchronize the line, walk the frame, emit a one-cycle valid or frame-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= RX_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              data  <= shreg;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter; accepts a new byte in the last stop-bit cycle so frames abut.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shreg;

  assign ready = !active || ((bit_idx == 4'd9) && (cnt == FULL));

  // Shift out start, data LSB first and stop, one bit per CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '1;
    end else if (start && ready) begin
      tx      <= 1'b0;
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= {1'b1, data};
    end else if (active) begin
      if (cnt == FULL) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_alu.sv
// UART command processor: packet parser, operand registers, 32-bit ALU and echo FIFO.
module uart_alu
  import uart_alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_i,
  output logic tx_o,
  output logic busy_o,
  output logic frame_err_o
);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_ready;

  parser_state_t state;
  logic          is_echo;
  logic          is_mul;
  logic [7:0]    len_lo;
  logic [15:0]   remaining;
  logic [3:0]    pay_idx;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic [31:0]   result;
  logic          res_loaded;
  logic [2:0]    res_left;

  logic [7:0]    fifo_mem [2];
  logic          fifo_rd;
  logic          fifo_wr;
  logic [1:0]    fifo_cnt;
  logic          fifo_push;
  logic          fifo_pop;
  logic [15:0]   len_full;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk_i),
    .rst       (reset_i),
    .rx        (rx_i),
    .data      (rx_data),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk_i),
    .rst   (reset_i),
    .start (tx_start),
    .data  (tx_data),
    .tx    (tx_o),
    .ready (tx_ready)
  );

  assign len_full  = {rx_data, len_lo};
  assign fifo_push = rx_valid && is_echo && (state == P_PAYLOAD) && (fifo_cnt != 2'd2);
  assign fifo_pop  = tx_start && is_echo;

  // Feed the transmitter from the echo FIFO or from the registered ALU result.
  always_comb begin
    tx_start = 1'b0;
    tx_data  = fifo_mem[fifo_rd];
    if (is_echo) begin
      tx_start = (fifo_cnt != 2'd0) && tx_ready;
    end else if ((state == P_DONE) && res_loaded && (res_left != 3'd0)) begin
      tx_start = tx_ready;
      tx_data  = result[7:0];
    end
  end

  // Echo FIFO: two entries, incoming byte dropped when full.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < 2; i++) fifo_mem[i] <= '0;
      fifo_rd  <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) begin
        fifo_mem[fifo_wr] <= rx_data;
        fifo_wr           <= ~fifo_wr;
      end
      if (fifo_pop) fifo_rd <= ~fifo_rd;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Parser, operand capture, ALU result register, busy and sticky frame error.
  // DONE leaves only when the transmitter reports its final stop-bit cycle, so
  // busy_o drops on the same edge the last stop bit completes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= P_IDLE;
      is_echo     <= 1'b0;
      is_mul      <= 1'b0;
      len_lo      <= '0;
      remaining   <= '0;
      pay_idx     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      result      <= '0;
      res_loaded  <= 1'b0;
      res_left    <= '0;
      busy_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (rx_ferr) frame_err_o <= 1'b1;
      case (state)
        P_IDLE: begin
          if (rx_valid && is_opcode(rx_data)) begin
            state   <= P_RSVD;
            is_echo <= (rx_data == OP_ECHO);
            is_mul  <= (rx_data == OP_MUL32);
            op_a    <= '0;
            op_b    <= '0;
            pay_idx <= '0;
            busy_o  <= 1'b1;
          end
        end
        P_RSVD: begin
          if (rx_valid) state <= P_LEN_LO;
        end
        P_LEN_LO: begin
          if (rx_valid) begin
            len_lo <= rx_data;
            state  <= P_LEN_HI;
          end
        end
        P_LEN_HI: begin
          if (rx_valid) begin
            res_loaded <= 1'b0;
            if (len_full <= 16'(HDR_BYTES)) begin
              state <= P_DONE;
            end else begin
              remaining <= len_full - 16'(HDR_BYTES);
              state     <= P_PAYLOAD;
            end
          end
        end
        P_PAYLOAD: begin
          if (rx_valid) begin
            if (pay_idx != 4'd8) begin
              if (pay_idx[2]) op_b[{pay_idx[1:0], 3'b000} +: 8] <= rx_data;
              else            op_a[{pay_idx[1:0], 3'b000} +: 8] <= rx_data;
              pay_idx <= pay_idx + 4'd1;
            end
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) state <= P_DONE;
          end
        end
        P_DONE: begin
          if (is_echo) begin
            if ((fifo_cnt == 2'd0) && tx_ready) begin
              state  <= P_IDLE;
              busy_o <= 1'b0;
            end
          end else if (!res_loaded) begin
            result     <= is_mul ? (op_a * op_b) : (op_a + op_b);
            res_loaded <= 1'b1;
            res_left   <= 3'd4;
          end else if (res_left != 3'd0) begin
            if (tx_start) begin
              result   <= {8'h00, result[31:8]};
              res_left <= res_left - 3'd1;
            end
          end else if (tx_ready) begin
            state  <= P_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu.sv
// Scoreboard bench for uart_alu: packets drive the RX line, a reference model
// queues the expected reply bytes, and a TX monitor decodes and compares them.
module tb_uart_alu;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic rx_i = 1'b1;
  logic tx_o;
  logic busy_o;
  logic frame_err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int frames_seen = 0;
  int abort_cnt = 0;
  bit busy_seen = 1'b0;

  always #5 clk = ~clk;

  uart_alu #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (busy_o) busy_seen = 1'b1;

  // TX monitor: decode each frame, sampling every bit early, mid and late.
  initial begin
    forever begin
      logic [7:0] b;
      logic st, sp, sa, sm, sb, timing_ok;
      int my_abort;
      @(negedge tx_o);
      my_abort  = abort_cnt;
      timing_ok = 1'b1;
      st = 1'b1;
      sp = 1'b0;
      b  = '0;
      for (int k = 0; k < 10; k++) begin
        for (int m = 1; m <= int'(CPB); m++) begin
          @(negedge clk);
          if (m == 2) sa = tx_o;
          if (m == int'(CPB / 2)) sm = tx_o;
          if (m == int'(CPB) - 1) sb = tx_o;
        end
        if (!(sa == sm && sm == sb)) timing_ok = 1'b0;
        if (k == 0) st = sm;
        else if (k == 9) sp = sm;
        else b[k-1] = sm;
      end
      if (my_abort == abort_cnt && !reset_i) begin
        frames_seen++;
        check("tx_bit_timing", {31'd0, timing_ok}, 32'd1);
        check("tx_start_stop", {30'd0, st, sp}, 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected_byte: got %0h expected no byte", b);
        end else begin
          check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached, %0d expected bytes outstanding", exp_q.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = stop_ok;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  // Reference model: echo returns the payload; arithmetic returns 4 bytes of
  // (A op B) mod 2^32 with A, B assembled little-endian, absent bytes zero.
  task automatic send_packet(input logic [7:0] op, input logic [15:0] len, input logic [7:0] pl[$]);
    longint unsigned a, b, r;
    if (op == 8'hEC) begin
      foreach (pl[i]) exp_q.push_back(pl[i]);
    end else begin
      a = 0;
      b = 0;
      for (int i = 0; i < pl.size() && i < 8; i++) begin
        if (i < 4) a = a + (64'(pl[i]) << (8 * i));
        else       b = b + (64'(pl[i]) << (8 * (i - 4)));
      end
      r = (op == 8'hA0) ? (a + b) : (a * b);
      r = r % 64'h1_0000_0000;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((r >> (8 * i)) & 64'hFF));
    end
    send_byte(op, 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
    foreach (pl[i]) send_byte(pl[i], 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_low"}, {31'd0, busy_o}, 32'd0);
    check({name, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] op, junk;
    logic [15:0] len;
    int f0, np;

    reset_i = 1'b1;
    rx_i    = 1'b1;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_tx", {31'd0, tx_o}, 32'd1);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_ferr", {31'd0, frame_err_o}, 32'd0);

    // Lone non-opcode byte is ignored.
    busy_seen = 1'b0;
    f0 = frames_seen;
    send_byte(8'h55, 1'b1);
    repeat (5000) @(negedge clk);
    check("junk_no_tx", frames_seen, f0);
    check("junk_no_busy", {31'd0, busy_seen}, 32'd0);

    busy_seen = 1'b0;
    pl = {8'h48, 8'h69};
    send_packet(8'hEC, 16'd6, pl);
    wait_idle("echo_hi");
    check("echo_hi_busy_rose", {31'd0, busy_seen}, 32'd1);

    pl = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_packet(8'hA0, 16'd12, pl);
    wait_idle("add_wrap");

    pl = {8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    send_packet(8'hB0, 16'd12, pl);
    wait_idle("mul_trunc");

    pl = {8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_packet(8'hB0, 16'd12, pl);
    wait_idle("mul_small");

    // Short length and missing/extra operand bytes.
    pl = {};
    send_packet(8'hA0, 16'd2, pl);
    wait_idle("add_short_len");
    pl = {8'h10, 8'h20, 8'h30};
    send_packet(8'hA0, 16'd7, pl);
    wait_idle("add_missing");
    pl = {8'h07, 8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send_packet(8'hB0, 16'd14, pl);
    wait_idle("mul_extra");

    // Randomized packets, each preceded by a junk byte.
    for (int n = 0; n < 7; n++) begin
      do junk = 8'($urandom); while (junk == 8'hEC || junk == 8'hA0 || junk == 8'hB0);
      send_byte(junk, 1'b1);
      case ($urandom_range(0, 2))
        0:       op = 8'hEC;
        1:       op = 8'hA0;
        default: op = 8'hB0;
      endcase
      len = 16'($urandom_range(0, 13));
      np  = (len < 16'd4) ? 0 : int'(len) - 4;
      pl = {};
      for (int i = 0; i < np; i++) pl.push_back(8'($urandom));
      send_packet(op, len, pl);
      wait_idle("rand_pkt");
    end

    // Bad stop bit: sticky error, byte not treated as an opcode.
    send_byte(8'hEC, 1'b0);
    repeat (10 * CPB) @(negedge clk);
    check("ferr_set", {31'd0, frame_err_o}, 32'd1);
    check("ferr_byte_dropped", {31'd0, busy_o}, 32'd0);
    pl = {8'h5A};
    send_packet(8'hEC, 16'd5, pl);
    wait_idle("echo_after_ferr");
    check("ferr_sticky", {31'd0, frame_err_o}, 32'd1);

    // Reset in the middle of an echo transmission.
    pl = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    send_packet(8'hEC, 16'd8, pl);
    repeat (3 * CPB) @(negedge clk);
    @(posedge clk);
    #2 reset_i = 1'b1;
    abort_cnt++;
    #1;
    check("midreset_tx_high", {31'd0, tx_o}, 32'd1);
    check("midreset_busy_low", {31'd0, busy_o}, 32'd0);
    check("midreset_ferr_clr", {31'd0, frame_err_o}, 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    reset_i = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    pl = {8'h48, 8'h69};
    send_packet(8'hEC, 16'd6, pl);
    wait_idle("echo_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
